// File: rtl/keypad_scan_if.sv
// Keypad bus between the scanner and the keypad matrix.
//   row_in    : row lines from the keypad, active-low, pulled up, asynchronous
//   col_out   : column drive, active-low, one bit low at a time
//   key_code  : last accepted key, row_idx*4 + col_idx
//   key_valid : one-clock pulse per accepted press
//   key_down  : high while the accepted key is held
// The master modport is the scanner; the slave modport is the keypad side.
interface keypad_scan_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    modport master (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_down
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_down
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce and no rollover.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   kp  : keypad bus (master side), see keypad_scan_if
// One column is driven low per dwell period of SCAN_DIV clocks. Rows are
// examined once per dwell (the "tick"); a press or release must be seen on
// DEBOUNCE_N consecutive ticks before it is accepted.
module keypad_scan #(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned DEBOUNCE_N = 4
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master kp
);

    localparam int unsigned DWELL_W   = 16;
    localparam int unsigned CNT_W     = 4;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_DONE   = CNT_W'(DEBOUNCE_N);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HELD,
        S_RELEASE
    } state_e;

    state_e             state_q;
    logic [3:0]         sync1_q;
    logic [3:0]         rows_s_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         col_idx_q;
    logic [1:0]         row_idx_q;
    logic [3:0]         col_out_q;
    logic [3:0]         key_code_q;
    logic               key_valid_q;
    logic               key_down_q;

    logic               tick_c;
    logic               any_low_c;
    logic [1:0]         hit_row_c;
    logic               row_low_c;
    logic [1:0]         col_idx_d;
    logic [3:0]         col_out_d;
    logic [CNT_W-1:0]   cnt_inc_c;

    // Column index to active-low one-hot drive: 0 -> 0111 ... 3 -> 1110
    function automatic logic [3:0] col_decode(input logic [1:0] idx);
        return ~(4'b1000 >> idx);
    endfunction

    // Row synchronizer; idle rows read high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 4'hF;
            rows_s_q <= 4'hF;
        end else begin
            sync1_q  <= kp.row_in;
            rows_s_q <= sync1_q;
        end
    end

    // Dwell counter; the last count of each dwell is the tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_q <= '0;
        end else if (tick_c) begin
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_q + DWELL_W'(1);
        end
    end

    // Tick, lowest-index hit row, latched-row level and next column
    always_comb begin
        tick_c    = (dwell_q == DWELL_LAST);
        any_low_c = ~(&rows_s_q);
        hit_row_c = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_s_q[i]) begin
                hit_row_c = 2'(i);
            end
        end
        row_low_c = ~rows_s_q[row_idx_q];
        col_idx_d = col_idx_q + 2'd1;
        col_out_d = col_decode(col_idx_d);
        cnt_inc_c = cnt_q + CNT_W'(1);
    end

    // Scan / debounce state machine with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_SCAN;
            cnt_q       <= '0;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            col_out_q   <= 4'b0111;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (tick_c) begin
                unique case (state_q)
                    S_SCAN: begin
                        if (any_low_c) begin
                            row_idx_q <= hit_row_c;
                            cnt_q     <= CNT_W'(1);
                            if (DEBOUNCE_N == 1) begin
                                state_q     <= S_HELD;
                                key_code_q  <= {hit_row_c, col_idx_q};
                                key_valid_q <= 1'b1;
                                key_down_q  <= 1'b1;
                            end else begin
                                state_q <= S_DEBOUNCE;
                            end
                        end else begin
                            col_idx_q <= col_idx_d;
                            col_out_q <= col_out_d;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (row_low_c) begin
                            cnt_q <= cnt_inc_c;
                            if (cnt_inc_c == CNT_DONE) begin
                                state_q     <= S_HELD;
                                key_code_q  <= {row_idx_q, col_idx_q};
                                key_valid_q <= 1'b1;
                                key_down_q  <= 1'b1;
                            end
                        end else begin
                            // Bounce: drop the candidate and move on
                            cnt_q     <= '0;
                            col_idx_q <= col_idx_d;
                            col_out_q <= col_out_d;
                            state_q   <= S_SCAN;
                        end
                    end
                    S_HELD: begin
                        if (!row_low_c) begin
                            if (DEBOUNCE_N == 1) begin
                                cnt_q      <= '0;
                                key_down_q <= 1'b0;
                                col_idx_q  <= col_idx_d;
                                col_out_q  <= col_out_d;
                                state_q    <= S_SCAN;
                            end else begin
                                cnt_q   <= CNT_W'(1);
                                state_q <= S_RELEASE;
                            end
                        end
                    end
                    S_RELEASE: begin
                        if (!row_low_c) begin
                            cnt_q <= cnt_inc_c;
                            if (cnt_inc_c == CNT_DONE) begin
                                cnt_q      <= '0;
                                key_down_q <= 1'b0;
                                col_idx_q  <= col_idx_d;
                                col_out_q  <= col_out_d;
                                state_q    <= S_SCAN;
                            end
                        end else begin
                            // Key came back: still the same press, no new pulse
                            cnt_q   <= '0;
                            state_q <= S_HELD;
                        end
                    end
                    default: begin
                        state_q <= S_SCAN;
                    end
                endcase
            end
        end
    end

    assign kp.col_out   = col_out_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = key_down_q;

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clocks per column dwell; legal range 4..65535.
REQ-002 SHALL have parameter DEBOUNCE_N, default 4, consecutive tick samples to accept a press or release; legal range 1..15.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port row_in  input  4  keypad row lines, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port col_out  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port key_code  output  4  last accepted key, code = row_idx*4 + col_idx.
REQ-008 SHALL have port key_valid  output  1  one-clock pulse when a press is accepted.
REQ-009 SHALL have port key_down  output  1  level, high while an accepted key is held.

Function
REQ-010 SHALL pass row_in through a 2-flop synchronizer (reset value 4'hF); all decisions use the synchronized value rows_s.
REQ-011 SHALL run a dwell counter 0..SCAN_DIV-1 wrapping to 0; "tick" is the cycle the counter equals SCAN_DIV-1.
REQ-012 SHALL drive col_out from col_idx: 0 -> 4'b0111, 1 -> 4'b1011, 2 -> 4'b1101, 3 -> 4'b1110.
REQ-013 SHALL evaluate rows only on tick; the hit row is the lowest index i with rows_s[i]==0; ties resolve to lowest index.
REQ-014 SHALL implement states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-015 SCAN: on tick with no row low, col_idx SHALL advance modulo 4 (3 wraps to 0); on tick with a row low, the block SHALL latch row_idx, hold col_idx, set cnt=1, and go to DEBOUNCE (go directly to HELD if DEBOUNCE_N==1).
REQ-016 DEBOUNCE: col_idx frozen; on tick, if the latched row is low, cnt SHALL increment; on reaching DEBOUNCE_N, go to HELD; if the latched row is high, cnt SHALL clear, col_idx SHALL advance, and the block SHALL return to SCAN.
REQ-017 On entry to HELD: key_code SHALL update to row_idx*4+col_idx and key_valid SHALL be high for exactly that one clock.
REQ-018 HELD: key_down=1, col_idx frozen; on tick with the latched row high, set cnt=1 and go to RELEASE (to SCAN if DEBOUNCE_N==1).
REQ-019 RELEASE: key_down stays 1; on tick with the latched row high, cnt SHALL increment and on reaching DEBOUNCE_N go to SCAN with key_down=0 and col_idx advanced; on tick with the latched row low, cnt SHALL clear and the block SHALL return to HELD without a new key_valid.
REQ-020 Other keys pressed while in DEBOUNCE/HELD/RELEASE SHALL be ignored (no rollover); only the latched row is examined.
REQ-021 key_code SHALL hold its value until the next accepted press; key_valid SHALL never assert on consecutive clocks.
REQ-022 Counter widths SHALL be 16 bits (dwell) and 4 bits (cnt); no overflow is possible within legal parameter ranges.

Reset
REQ-023 While rst=1, outputs SHALL be: col_out=4'b0111, key_code=0, key_valid=0, key_down=0; state=SCAN, col_idx=0, dwell counter=0, cnt=0, and synchronizer=4'hF.
REQ-024 Reset asserted mid-debounce or mid-hold SHALL abort without a key_valid pulse; after deassertion, scanning SHALL restart at column 0.

Verification (SCAN_DIV=4, DEBOUNCE_N=3)
REQ-025 Idle: row_in=4'hF for 40 clocks -> col_out cycles 0111,1011,1101,1110 every 4 clocks and wraps; key_valid never high.
REQ-026 Press row 2 while col 1 low, held -> exactly one key_valid pulse after the 3rd low tick; key_code=9; key_down=1.
REQ-027 Bounce: row low for 2 ticks, then high on the 3rd -> no key_valid; scan resumes with col_idx advanced to 2.
REQ-028 Release: from HELD, row high for 2 ticks, low 1 tick, then high 3 ticks -> key_down stays 1 until the 3rd consecutive high tick, then 0; a single key_valid overall.
REQ-029 Rows 1 and 3 low together at col 3 -> key_code=7 (row 1 wins).
REQ-030 rst pulsed during DEBOUNCE -> key_valid=0, col_out=4'b0111 immediately; key_code retains 0.
